bram_fifo: RTL and testbench

BRAM_FIFO -- requirements
Module: bram_fifo

---
 rtl/bram_fifo.sv | 133 +++++++++++++
 tb/tb_bram_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO built on a simple dual-port BRAM with two-cycle read latency.
// A three-entry skid buffer absorbs reads that are already in flight when the consumer stalls.

module bramsd #(
  parameter int ADDR_ = 8,
  parameter int DATA_ = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             we,
  input  logic [ADDR_-1:0] waddr,
  input  logic [ADDR_-1:0] raddr,
  input  logic [DATA_-1:0] din,
  output logic [DATA_-1:0] dout
);

  logic [DATA_-1:0] mem [2**ADDR_];
  logic [ADDR_-1:0] raddr_q;
  logic [DATA_-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  // Registered address plus registered output give the two-cycle read latency.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      raddr_q <= '0;
      dout_q  <= '0;
    end else begin
      raddr_q <= raddr;
      dout_q  <= mem[raddr_q];
    end
  end

  assign dout = dout_q;

endmodule

module bram_fifo #(
  parameter int ADDR_ = 8,
  parameter int DATA_ = 8
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATA_-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA_-1:0] out_data,
  output logic [ADDR_+1:0] count
);

  localparam logic [ADDR_:0] FULL_OCC = {1'b1, {ADDR_{1'b0}}};

  logic [ADDR_:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, bramOcc;
  logic             pipe1_q, pipe1_d, pipe2_q, pipe2_d;
  logic [DATA_-1:0] skid_q [3];
  logic [DATA_-1:0] skid_d [3];
  logic [1:0]       skidCnt_q, skidCnt_d, cntAfterPop;
  logic [2:0]       pending;
  logic             inXfer, outXfer, rdIssue;
  logic [DATA_-1:0] dout;

  assign bramOcc  = wrPtr_q - rdPtr_q;
  assign in_ready = aclr_n && !flush && (bramOcc != FULL_OCC);
  assign inXfer   = in_valid && in_ready;

  assign out_valid = (skidCnt_q != 2'd0);
  assign out_data  = skid_q[0];
  assign outXfer   = out_valid && out_ready;

  // Words bound for the skid after this edge; counting this cycle's pop keeps full throughput.
  assign pending = 3'(skidCnt_q) - 3'(outXfer) + 3'(pipe1_q) + 3'(pipe2_q);
  assign rdIssue = !flush && (bramOcc != '0) && (pending <= 3'd2);

  assign count = {1'b0, bramOcc} + (ADDR_+2)'(pipe1_q) + (ADDR_+2)'(pipe2_q)
               + (ADDR_+2)'(skidCnt_q);

  bramsd #(.ADDR_(ADDR_), .DATA_(DATA_)) u_bram (
    .clk   (clk),
    .aclr  (!aclr_n),
    .we    (inXfer),
    .waddr (wrPtr_q[ADDR_-1:0]),
    .raddr (rdPtr_q[ADDR_-1:0]),
    .din   (in_data),
    .dout  (dout)
  );

  always_comb begin
    wrPtr_d     = wrPtr_q + (ADDR_+1)'(inXfer);
    rdPtr_d     = flush ? wrPtr_q : rdPtr_q + (ADDR_+1)'(rdIssue);
    pipe1_d     = rdIssue;
    pipe2_d     = pipe1_q && !flush;
    skid_d      = skid_q;
    skidCnt_d   = skidCnt_q;
    cntAfterPop = skidCnt_q - 2'(outXfer);
    if (flush) begin
      skidCnt_d = 2'd0;
    end else begin
      if (outXfer) begin
        skid_d[0] = skid_q[1];
        skid_d[1] = skid_q[2];
      end
      skidCnt_d = cntAfterPop;
      if (pipe2_q) begin
        skid_d[cntAfterPop] = dout;
        skidCnt_d           = cntAfterPop + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      pipe1_q   <= 1'b0;
      pipe2_q   <= 1'b0;
      skidCnt_q <= 2'd0;
      for (int i = 0; i < 3; i++) skid_q[i] <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      pipe1_q   <= pipe1_d;
      pipe2_q   <= pipe2_d;
      skidCnt_q <= skidCnt_d;
      skid_q    <= skid_d;
    end
  end

endmodule

// File: tb/tb_bram_fifo.sv
// Directed bench for bram_fifo with a 4-word BRAM; each task drives one scenario and checks inline.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.

module tb_bram_fifo;

  logic       clk;
  logic       aclr_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  bram_fifo #(.ADDR_(2), .DATA_(8)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    aclr_n    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
  endtask

  task automatic test_reset();
    aclr_n    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    @(negedge clk);
    aclr_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  // Single word into an empty FIFO: visible exactly four cycles after acceptance.
  task automatic test_latency();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 3) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL latency_early: got %b expected 0", out_valid); end
      end
      if (c == 4) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL latency_valid: got %b expected 1", out_valid); end
        total++; if (out_data !== 8'h11) begin bad++; $display("[TB] FAIL latency_data: got %h expected 11", out_data); end
      end
      if (c == 5) begin
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL latency_count: got %0d expected 0", count); end
      end
    end
  endtask

  // Continuous writes with the consumer always ready must give one word per cycle.
  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 3 || c == 10) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_c%0d: got %b expected 0", c, out_valid); end
      end
      if (c >= 4 && c <= 9) begin
        total++; if (out_valid !== 1'b1 || out_data !== 8'(8'h20 + c - 4)) begin
          bad++; $display("[TB] FAIL b2b_word_c%0d: got v=%b d=%h expected v=1 d=%h", c, out_valid, out_data, 8'(8'h20 + c - 4));
        end
      end
      if (c == 5 || c == 6) begin
        total++; if (count !== 4'd4) begin bad++; $display("[TB] FAIL b2b_count_c%0d: got %0d expected 4", c, count); end
      end
      in_valid = (c < 6);
      in_data  = 8'(8'h20 + c);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Stalled consumer: BRAM full with four words and skid holding three.
  task automatic test_fill_drain();
    int rcvd;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_ready_%0d: got %b expected 1", i, in_ready); end
      @(negedge clk);
    end
    in_data = 8'h08;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_full_ready: got %b expected 0", in_ready); end
    total++; if (count !== 4'd7) begin bad++; $display("[TB] FAIL fill_count: got %0d expected 7", count); end
    @(negedge clk);
    @(negedge clk);
    total++; if (out_data !== 8'h01) begin bad++; $display("[TB] FAIL fill_head_stable: got %h expected 01", out_data); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 7; c++) begin
      if (out_valid) begin
        total++; if (out_data !== 8'(rcvd + 1)) begin bad++; $display("[TB] FAIL drain_word_%0d: got %h expected %h", rcvd, out_data, 8'(rcvd + 1)); end
        rcvd++;
      end
      @(negedge clk);
    end
    total++; if (rcvd !== 7) begin bad++; $display("[TB] FAIL drain_total: got %0d expected 7", rcvd); end
    repeat (3) @(negedge clk);
    total++; if (count !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_empty: got count=%0d v=%b expected 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  // Twelve words through a four-deep BRAM with a fixed irregular ready pattern.
  task automatic test_stream();
    logic [15:0] readyPattern;
    logic [7:0]  held;
    logic        stalledPrev;
    int sent, rcvd;
    readyPattern = 16'b1011_0010_1110_0101;
    do_reset();
    sent = 0; rcvd = 0; stalledPrev = 1'b0; held = 8'h00;
    for (int c = 0; c < 300 && (sent < 12 || rcvd < 12); c++) begin
      if (stalledPrev) begin
        total++; if (out_valid !== 1'b1 || out_data !== held) begin
          bad++; $display("[TB] FAIL stream_stall_c%0d: got v=%b d=%h expected v=1 d=%h", c, out_valid, out_data, held);
        end
      end
      in_valid  = (sent < 12);
      in_data   = 8'(8'h80 + sent * 3);
      out_ready = readyPattern[c % 16];
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        total++; if (out_data !== 8'(8'h80 + rcvd * 3)) begin bad++; $display("[TB] FAIL stream_word_%0d: got %h expected %h", rcvd, out_data, 8'(8'h80 + rcvd * 3)); end
        rcvd++;
      end
      stalledPrev = out_valid && !out_ready;
      held        = out_data;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (rcvd !== 12) begin bad++; $display("[TB] FAIL stream_total: got %0d expected 12", rcvd); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL stream_count: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    int waitCycles;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h51 + i);
      @(negedge clk);
    end
    total++; if (count !== 4'd5) begin bad++; $display("[TB] FAIL flush_pre_count: got %0d expected 5", count); end
    flush   = 1'b1;
    in_data = 8'hEE;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("[TB] FAIL flush_cleared: got v=%b count=%0d expected 0 0", out_valid, count); end
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("[TB] FAIL flush_no_stale: got v=%b count=%0d expected 0 0", out_valid, count); end
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waitCycles = 0;
    while (!out_valid && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    total++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin bad++; $display("[TB] FAIL flush_first_out: got v=%b d=%h expected v=1 d=aa", out_valid, out_data); end
    @(negedge clk);
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL flush_final_count: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  // Reset lands with one word in the skid and two reads in flight.
  task automatic test_reset_midop();
    int firstCycle;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h61 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || count !== 4'd3) begin bad++; $display("[TB] FAIL midop_pre: got v=%b count=%0d expected 1 3", out_valid, count); end
    aclr_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("[TB] FAIL midop_async: got v=%b count=%0d expected 0 0", out_valid, count); end
    repeat (2) @(negedge clk);
    aclr_n    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hC3;
    out_ready = 1'b1;
    firstCycle = -1;
    for (int c = 1; c <= 10 && firstCycle < 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        firstCycle = c;
        total++; if (out_data !== 8'hC3) begin bad++; $display("[TB] FAIL midop_first_data: got %h expected c3", out_data); end
      end
    end
    total++; if (firstCycle !== 4) begin bad++; $display("[TB] FAIL midop_first_cycle: got %0d expected 4", firstCycle); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("[TB] FAIL midop_after: got v=%b count=%0d expected 0 0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_fill_drain();
    test_stream();
    test_flush();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
